multi_countdown_timer: RTL and testbench

// - N-channel countdown timer with a shared tick prescaler. This is the parametrised successor of the single 16-bit countdown.
// - Per channel: load/start, pause, resume, cancel, optional auto-reload, one-cycle done pulse and sticky expired flag.
// - Sits between the control FSM (issues commands) and the display/alarm logic (consumes time_left and done).

---
 rtl/multi_countdown_timer.sv | 169 ++++++++++++++++
 tb/tb_multi_countdown_timer.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/multi_countdown_timer.sv
// rtl/multi_countdown_timer.sv - N-channel countdown timer with shared tick prescaler
//
// Ports:
//   clk         system clock, all logic on posedge
//   rst         asynchronous, active-high reset
//   cmd_valid   command strobe, one command per cycle
//   cmd_op      00 LOAD, 01 PAUSE, 10 RESUME, 11 CANCEL
//   cmd_ch      target channel
//   cmd_value   LOAD start value in ticks
//   cmd_reload  LOAD: 1 = auto-reload mode
//   time_left   remaining ticks, channel i at [i*WIDTH +: WIDTH]
//   running     channel is counting
//   expired     sticky, channel reached terminal count without reload
//   done_pulse  one-cycle pulse at each terminal count
//   cmd_err     one-cycle pulse, previous command was ignored

module multi_countdown_timer #(
    parameter int N_CH     = 2,
    parameter int WIDTH    = 16,
    parameter int TICK_DIV = 100_000_000
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  cmd_valid,
    input  logic [1:0]                            cmd_op,
    input  logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0] cmd_ch,
    input  logic [WIDTH-1:0]                      cmd_value,
    input  logic                                  cmd_reload,
    output logic [N_CH*WIDTH-1:0]                 time_left,
    output logic [N_CH-1:0]                       running,
    output logic [N_CH-1:0]                       expired,
    output logic [N_CH-1:0]                       done_pulse,
    output logic                                  cmd_err
);

    localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

    localparam logic [1:0] OP_LOAD   = 2'b00;
    localparam logic [1:0] OP_PAUSE  = 2'b01;
    localparam logic [1:0] OP_RESUME = 2'b10;
    localparam logic [1:0] OP_CANCEL = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_RUN     = 2'b01,
        ST_PAUSED  = 2'b10,
        ST_EXPIRED = 2'b11
    } state_t;

    logic [PW-1:0]   prescaler;
    logic            tick;
    logic            ch_ok;
    logic [N_CH-1:0] ch_err;

    // Free-running prescaler shared by all channels; only reset clears it,
    // so LOAD does not restart the tick phase.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prescaler <= '0;
        end else if (prescaler == PRE_LAST) begin
            prescaler <= '0;
        end else begin
            prescaler <= prescaler + PW'(1);
        end
    end

    assign tick  = (prescaler == PRE_LAST);
    assign ch_ok = (32'(cmd_ch) < N_CH);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd_err <= 1'b0;
        end else begin
            cmd_err <= cmd_valid && (!ch_ok || (|ch_err));
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        state_t           state, state_n;
        logic [WIDTH-1:0] tl, tl_n;
        logic [WIDTH-1:0] rv, rv_n;
        logic             rl, rl_n;
        logic             done_q, done_n;
        logic             err_n;
        logic             hit;

        assign hit = cmd_valid && ch_ok && (cmd_ch == CH_W'(i));

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state  <= ST_IDLE;
                tl     <= '0;
                rv     <= '0;
                rl     <= 1'b0;
                done_q <= 1'b0;
            end else begin
                state  <= state_n;
                tl     <= tl_n;
                rv     <= rv_n;
                rl     <= rl_n;
                done_q <= done_n;
            end
        end

        // A command addressed to this channel takes priority; a tick arriving
        // in the same cycle is dropped for this channel only.
        always_comb begin
            state_n = state;
            tl_n    = tl;
            rv_n    = rv;
            rl_n    = rl;
            done_n  = 1'b0;
            err_n   = 1'b0;
            if (hit) begin
                case (cmd_op)
                    OP_LOAD: begin
                        tl_n = cmd_value;
                        rv_n = cmd_value;
                        if (cmd_value == '0) begin
                            // Zero load expires at once; reload is forced off
                            // so it cannot pulse forever.
                            state_n = ST_EXPIRED;
                            rl_n    = 1'b0;
                            done_n  = 1'b1;
                        end else begin
                            state_n = ST_RUN;
                            rl_n    = cmd_reload;
                        end
                    end
                    OP_PAUSE: begin
                        if (state == ST_RUN) state_n = ST_PAUSED;
                        else                 err_n   = 1'b1;
                    end
                    OP_RESUME: begin
                        if (state == ST_PAUSED) state_n = ST_RUN;
                        else                    err_n   = 1'b1;
                    end
                    OP_CANCEL: begin
                        state_n = ST_IDLE;
                        tl_n    = '0;
                        rl_n    = 1'b0;
                    end
                    default: ;
                endcase
            end else if (tick && state == ST_RUN) begin
                if (tl > WIDTH'(1)) begin
                    tl_n = tl - WIDTH'(1);
                end else if (tl == WIDTH'(1)) begin
                    done_n = 1'b1;
                    if (rl) begin
                        tl_n = rv;
                    end else begin
                        tl_n    = '0;
                        state_n = ST_EXPIRED;
                    end
                end
            end
        end

        assign ch_err[i]                    = err_n;
        assign time_left[i*WIDTH +: WIDTH]  = tl;
        assign running[i]                   = (state == ST_RUN);
        assign expired[i]                   = (state == ST_EXPIRED);
        assign done_pulse[i]                = done_q;
    end

endmodule

// File: tb/tb_multi_countdown_timer.sv
// tb/tb_multi_countdown_timer.sv - directed self-checking bench for multi_countdown_timer

module tb_multi_countdown_timer;

    localparam logic [1:0] LOAD   = 2'b00;
    localparam logic [1:0] PAUSE  = 2'b01;
    localparam logic [1:0] RESUME = 2'b10;
    localparam logic [1:0] CANCEL = 2'b11;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic [1:0]  cmd_op;
    logic        cmd_ch;
    logic [7:0]  cmd_value;
    logic        cmd_reload;
    logic [15:0] time_left;
    logic [1:0]  running;
    logic [1:0]  expired;
    logic [1:0]  done_pulse;
    logic        cmd_err;

    logic        cmd_valid2;
    logic [1:0]  cmd_ch2;
    logic [23:0] time_left2;
    logic [2:0]  running2;
    logic [2:0]  expired2;
    logic [2:0]  done_pulse2;
    logic        cmd_err2;

    int checks   = 0;
    int failures = 0;
    int ph       = 0;
    bit tick_applied;

    always #5 clk = ~clk;

    multi_countdown_timer #(.N_CH(2), .WIDTH(8), .TICK_DIV(4)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_op(cmd_op),
        .cmd_ch(cmd_ch), .cmd_value(cmd_value), .cmd_reload(cmd_reload),
        .time_left(time_left), .running(running), .expired(expired),
        .done_pulse(done_pulse), .cmd_err(cmd_err)
    );

    multi_countdown_timer #(.N_CH(3), .WIDTH(8), .TICK_DIV(4)) dut3 (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid2), .cmd_op(cmd_op),
        .cmd_ch(cmd_ch2), .cmd_value(cmd_value), .cmd_reload(cmd_reload),
        .time_left(time_left2), .running(running2), .expired(expired2),
        .done_pulse(done_pulse2), .cmd_err(cmd_err2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ph models the prescaler value; a tick takes effect at an edge where ph was 3.
    task automatic step();
        @(posedge clk);
        tick_applied = (ph == 3);
        ph = (ph + 1) % 4;
        #1;
    endtask

    task automatic cmd(input logic [1:0] op, input logic ch, input logic [7:0] val, input logic rl);
        cmd_valid  = 1'b1;
        cmd_op     = op;
        cmd_ch     = ch;
        cmd_value  = val;
        cmd_reload = rl;
        step();
        cmd_valid  = 1'b0;
    endtask

    task automatic run_to_tick();
        int n = 0;
        do begin
            step();
            n++;
        end while (!tick_applied && n < 8);
        if (!tick_applied) chk("tick_timeout", 0, 1);
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_ch = 1'b0;
        cmd_value = 8'h00; cmd_reload = 1'b0; cmd_valid2 = 1'b0; cmd_ch2 = 2'b00;
        #12;
        chk("rst_time_left", time_left, 16'h0000);
        chk("rst_running", running, 2'b00);
        chk("rst_expired", expired, 2'b00);
        chk("rst_done", done_pulse, 2'b00);
        chk("rst_cmd_err", cmd_err, 1'b0);
        @(posedge clk); #1; rst = 1'b0; ph = 0;

        // One-shot countdown on ch0
        cmd(LOAD, 1'b0, 8'd3, 1'b0);
        chk("a_load_tl0", time_left[7:0], 8'd3);
        chk("a_load_run", running, 2'b01);
        run_to_tick(); chk("a_tl0_2", time_left[7:0], 8'd2); chk("a_done_0", done_pulse, 2'b00);
        run_to_tick(); chk("a_tl0_1", time_left[7:0], 8'd1);
        run_to_tick();
        chk("a_tl0_0", time_left[7:0], 8'd0);
        chk("a_expired", expired, 2'b01);
        chk("a_done", done_pulse, 2'b01);
        chk("a_run_off", running, 2'b00);
        step();
        chk("a_done_clr", done_pulse, 2'b00);
        chk("a_exp_hold", expired, 2'b01);
        run_to_tick(); chk("a_tl0_stay0", time_left[7:0], 8'd0);

        // Auto-reload on ch1, then cancel
        cmd(LOAD, 1'b1, 8'd2, 1'b1);
        chk("b_tl1_2", time_left[15:8], 8'd2);
        chk("b_run", running, 2'b10);
        run_to_tick(); chk("b_tl1_1", time_left[15:8], 8'd1); chk("b_done_0", done_pulse, 2'b00);
        run_to_tick(); chk("b_tl1_rl", time_left[15:8], 8'd2); chk("b_done_1", done_pulse, 2'b10);
        chk("b_exp", expired, 2'b01);
        run_to_tick(); chk("b_tl1_1b", time_left[15:8], 8'd1); chk("b_done_0b", done_pulse, 2'b00);
        run_to_tick(); chk("b_tl1_rl2", time_left[15:8], 8'd2); chk("b_done_2", done_pulse, 2'b10);
        cmd(CANCEL, 1'b1, 8'd0, 1'b0);
        chk("b_cancel_tl1", time_left[15:8], 8'd0);
        chk("b_cancel_run", running, 2'b00);
        chk("b_cancel_done", done_pulse, 2'b00);

        // Pause / resume on ch0, bad PAUSE on idle ch1
        cmd(LOAD, 1'b0, 8'd6, 1'b0);
        chk("c_tl0_6", time_left[7:0], 8'd6);
        chk("c_exp_clr", expired, 2'b00);
        run_to_tick(); chk("c_tl0_5", time_left[7:0], 8'd5);
        run_to_tick(); chk("c_tl0_4", time_left[7:0], 8'd4);
        cmd(PAUSE, 1'b0, 8'd0, 1'b0);
        chk("c_paused_run", running, 2'b00);
        for (int k = 0; k < 5; k++) run_to_tick();
        chk("c_held_tl0", time_left[7:0], 8'd4);
        cmd(RESUME, 1'b0, 8'd0, 1'b0);
        chk("c_resume_run", running, 2'b01);
        chk("c_resume_tl0", time_left[7:0], 8'd4);
        run_to_tick(); chk("c_tl0_3", time_left[7:0], 8'd3);
        run_to_tick(); chk("c_tl0_2b", time_left[7:0], 8'd2);
        cmd(PAUSE, 1'b1, 8'd0, 1'b0);
        chk("c_err", cmd_err, 1'b1);
        chk("c_err_run", running, 2'b01);
        chk("c_err_tl1", time_left[15:8], 8'd0);
        step();
        chk("c_err_clr", cmd_err, 1'b0);

        // PAUSE coinciding with a tick: command wins on ch0, ch1 still ticks
        while (ph != 0) step();
        cmd(LOAD, 1'b0, 8'd5, 1'b0);
        cmd(LOAD, 1'b1, 8'd6, 1'b0);
        run_to_tick();
        chk("d_tl0_4", time_left[7:0], 8'd4);
        chk("d_tl1_5", time_left[15:8], 8'd5);
        while (ph != 3) step();
        cmd(PAUSE, 1'b0, 8'd0, 1'b0);
        chk("d_tl0_hold", time_left[7:0], 8'd4);
        chk("d_tl1_dec", time_left[15:8], 8'd4);
        chk("d_run", running, 2'b10);

        // Zero load with reload requested: single pulse, then quiet
        cmd(LOAD, 1'b0, 8'd0, 1'b1);
        chk("e_exp", expired, 2'b01);
        chk("e_done", done_pulse, 2'b01);
        chk("e_tl0", time_left[7:0], 8'd0);
        chk("e_run", running, 2'b10);
        step();
        chk("e_done_clr", done_pulse, 2'b00);
        run_to_tick(); chk("e_no_pulse1", done_pulse, 2'b00);
        run_to_tick(); chk("e_no_pulse2", done_pulse, 2'b00);
        chk("e_exp_hold", expired, 2'b01);

        // Asynchronous reset mid-count
        cmd(LOAD, 1'b0, 8'd5, 1'b0);
        chk("f_pre_tl0", time_left[7:0], 8'd5);
        #2; rst = 1'b1; #1;
        chk("f_rst_tl", time_left, 16'h0000);
        chk("f_rst_run", running, 2'b00);
        chk("f_rst_exp", expired, 2'b00);
        chk("f_rst_done", done_pulse, 2'b00);
        @(posedge clk); #1; rst = 1'b0; ph = 0;
        run_to_tick();
        chk("f_idle_tl", time_left, 16'h0000);
        chk("f_idle_run", running, 2'b00);
        cmd(LOAD, 1'b0, 8'd2, 1'b0);
        chk("f_reload_tl0", time_left[7:0], 8'd2);
        run_to_tick();
        chk("f_tl0_1", time_left[7:0], 8'd1);
        chk("f_run", running, 2'b01);

        // Out-of-range channel on a 3-channel instance
        cmd_valid2 = 1'b1; cmd_ch2 = 2'd2; cmd_op = LOAD; cmd_value = 8'd7; cmd_reload = 1'b0;
        step();
        cmd_valid2 = 1'b0;
        chk("g_tl2", time_left2[23:16], 8'd7);
        chk("g_run2", running2, 3'b100);
        chk("g_err_none", cmd_err2, 1'b0);
        cmd_valid2 = 1'b1; cmd_ch2 = 2'd3; cmd_op = CANCEL;
        step();
        cmd_valid2 = 1'b0;
        chk("g_err_oor", cmd_err2, 1'b1);
        chk("g_run2_keep", running2, 3'b100);
        chk("g_tl2_keep", (time_left2[23:16] != 8'd0), 1'b1);
        step();
        chk("g_err_clr", cmd_err2, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
